// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: control and status bundle between a player and tone_sequencer.
// The master side drives switches, mode and start; the slave side (the sequencer)
// returns the tone outputs, busy flag and current step index.
interface tone_sequencer_if #(
    parameter int NOTES = 8
);
    logic [NOTES-1:0] sw;
    logic [1:0]       mode;
    logic             start;
    logic [NOTES-1:0] tone;
    logic             busy;
    logic [2:0]       step_idx;

    modport master (
        output sw, mode, start,
        input  tone, busy, step_idx
    );

    modport slave (
        input  sw, mode, start,
        output tone, busy, step_idx
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: up to eight phase-continuous square-wave oscillators on the
// C4..C5 scale, gated either live from the switches or by a step sequencer
// (ascend, ping-pong, loop). Each step lasts BEAT_CYCLES clocks.
// Optional feature: define TONE_SEQUENCER_GAP_EN to insert GAP_CYCLES silent
// clocks between consecutive steps; without it steps are back-to-back.
module tone_sequencer #(
    parameter int CLK_HZ      = 25000000,
    parameter int NOTES       = 8,
    parameter int CW          = 20,
    parameter int BEAT_CYCLES = 6250000,
    parameter int GAP_CYCLES  = 250000
) (
    input  logic            clk,
    input  logic            rst,
    tone_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_LIVE     = 2'b00,
        MODE_ASCEND   = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_LOOP     = 2'b11
    } mode_e;

`ifdef TONE_SEQUENCER_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_e;
`endif

    // The beat counter is at least CW bits, widened when needed so the longest
    // interval it has to time always fits.
`ifdef TONE_SEQUENCER_GAP_EN
    localparam int MAX_INTERVAL = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
`else
    localparam int MAX_INTERVAL = BEAT_CYCLES;
`endif
    localparam int BW_NEED = $clog2(MAX_INTERVAL + 1);
    localparam int BW      = (CW > BW_NEED) ? CW : BW_NEED;

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
`ifdef TONE_SEQUENCER_GAP_EN
    localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_CYCLES - 1);
`else
    // GAP_CYCLES has no role without the gap state.
    logic [31:0] w_unused_gap;
    assign w_unused_gap = GAP_CYCLES;
`endif
    localparam logic [2:0] LAST_STEP = 3'(NOTES - 1);

    // Scale frequency of channel idx in Hz.
    function automatic int scale_hz(input int idx);
        case (idx)
            0:       scale_hz = 262;
            1:       scale_hz = 294;
            2:       scale_hz = 330;
            3:       scale_hz = 349;
            4:       scale_hz = 392;
            5:       scale_hz = 440;
            6:       scale_hz = 494;
            default: scale_hz = 523;
        endcase
    endfunction

    // Half-period in clocks, floored; clamped to 1 so a tiny CLK_HZ still toggles.
    function automatic logic [CW-1:0] half_of(input int idx);
        int h;
        h = CLK_HZ / (2 * scale_hz(idx));
        if (h < 1) h = 1;
        half_of = CW'(h);
    endfunction

    // ------------------------------------------------------------------
    // Oscillators: free-running, never touched by mode or gating.
    // ------------------------------------------------------------------
    logic [NOTES-1:0] w_osc;

    for (genvar g = 0; g < NOTES; g++) begin : g_osc
        localparam logic [CW-1:0] HALF_LAST = half_of(g) - CW'(1);
        logic [CW-1:0] r_cnt;
        logic          r_phase;

        // Count 0..HALF-1, then wrap and flip the phase: period is 2*HALF clocks.
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (r_cnt == HALF_LAST) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end

        assign w_osc[g] = r_phase;
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e           r_state;
    mode_e            r_mode;      // mode captured at start; any change aborts
    logic [2:0]       r_step;
    logic [BW-1:0]    r_beat;
    logic             r_down;      // ping-pong descending half
    logic             r_busy;
    logic [NOTES-1:0] r_tone;

    logic [NOTES-1:0] w_onehot;
    logic [NOTES-1:0] w_gate;
    logic [2:0]       w_next_step;
    logic             w_next_down;
    logic             w_final;
    logic             w_abort;

    assign w_onehot = NOTES'(1) << r_step;
    assign w_abort  = (bus.mode != r_mode) || ((r_mode == MODE_LOOP) && bus.start);

    // Channel gating: live switches in IDLE/LIVE, current step while playing, silence otherwise.
    // NOTE: default assignment first so no branch leaves w_gate unassigned and infers a latch.
    always_comb begin
        w_gate = '0;
        case (r_state)
            S_IDLE:  if (bus.mode == MODE_LIVE) w_gate = bus.sw;
            S_PLAY:  w_gate = w_onehot & bus.sw;
            default: w_gate = '0;
        endcase
    end

    // Where the sequence goes after the current beat, and whether this was the last one.
    always_comb begin
        w_next_step = r_step + 3'd1;
        w_next_down = r_down;
        w_final     = 1'b0;
        case (r_mode)
            MODE_ASCEND: w_final = (r_step == LAST_STEP);
            MODE_PINGPONG: begin
                if (r_down) begin
                    w_final     = (r_step == 3'd0);
                    w_next_step = r_step - 3'd1;
                end else if (r_step == LAST_STEP) begin
                    w_final     = (NOTES == 1);
                    w_next_step = r_step - 3'd1;
                    w_next_down = 1'b1;
                end
            end
            MODE_LOOP: if (r_step == LAST_STEP) w_next_step = 3'd0;
            default:   w_final = 1'b1;
        endcase
    end

    // Sequencer FSM with registered busy and step index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_LIVE;
            r_step  <= 3'd0;
            r_beat  <= '0;
            r_down  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.mode != MODE_LIVE)) begin
                        r_state <= S_PLAY;
                        r_mode  <= mode_e'(bus.mode);
                        r_step  <= 3'd0;
                        r_beat  <= '0;
                        r_down  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (w_abort) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end else if (r_beat == BEAT_LAST) begin
                        r_beat <= '0;
                        if (w_final) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_step <= w_next_step;
                            r_down <= w_next_down;
`ifdef TONE_SEQUENCER_GAP_EN
                            r_state <= S_GAP;
`endif
                        end
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
`ifdef TONE_SEQUENCER_GAP_EN
                S_GAP: begin
                    if (w_abort) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end else if (r_beat == GAP_LAST) begin
                        r_beat  <= '0;
                        r_state <= S_PLAY;
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
`endif
                S_DONE: r_state <= S_IDLE;
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered tone: oscillator phase masked by the gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tone <= '0;
        else     r_tone <= w_osc & w_gate;
    end

    assign bus.tone     = r_tone;
    assign bus.busy     = r_busy;
    assign bus.step_idx = r_step;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed stimulus against tone_sequencer with a cycle-level
// reference model derived from the step schedule (beat arithmetic, not FSM states).
// Optional build: TONE_SEQUENCER_GAP_EN adds GAP_CYCLES silent clocks between steps.
module tb_tone_sequencer;

    localparam int CLK_HZ = 5240;   // HALF = 10,8,7,7,6,5,5,5
    localparam int NOTES  = 8;
    localparam int CW     = 20;
    localparam int BEAT   = 40;
    localparam int GAP    = 4;

`ifdef TONE_SEQUENCER_GAP_EN
    localparam int GAP_T           = GAP;
    localparam int ASC_LEN         = 348;  // 8*40 + 7*4
    localparam int PP_LEN          = 656;  // 15*40 + 14*4
    localparam int ASC_PROBE_STEP  = 2;    // offset 120: slot 2 (44-clock slots)
    localparam int PP_PROBE_STEP   = 7;    // offset 320: slot 7
    localparam int LOOP_PROBE_STEP = 7;    // offset 330: slot 7
`else
    localparam int GAP_T           = 0;
    localparam int ASC_LEN         = 320;
    localparam int PP_LEN          = 600;
    localparam int ASC_PROBE_STEP  = 3;    // offset 120 / 40
    localparam int PP_PROBE_STEP   = 6;    // beat 8 of 0..7,6..0
    localparam int LOOP_PROBE_STEP = 0;    // beat 8 wraps to 0
`endif
    localparam int SLOT = BEAT + GAP_T;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tone_sequencer_if #(.NOTES(NOTES)) bus ();

    tone_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .NOTES      (NOTES),
        .CW         (CW),
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] k;       // clock edges since reset released
        logic        busy;
        logic        done;
        logic [1:0]  mode;
        logic [31:0] offset;  // clocks since the sequence started
        logic [2:0]  step;
        logic [7:0]  tone;
    } model_t;

    model_t m;

    function automatic int half_of(input int i);
        int f;
        case (i)
            0: f = 262; 1: f = 294; 2: f = 330; 3: f = 349;
            4: f = 392; 5: f = 440; 6: f = 494; default: f = 523;
        endcase
        half_of = CLK_HZ / (2 * f);
    endfunction

    // Square-wave level of every channel after k clocks: phase flips every HALF clocks.
    function automatic logic [7:0] osc_at(input int k);
        logic [7:0] o;
        for (int i = 0; i < NOTES; i++) o[i] = ((k / half_of(i)) % 2) == 1;
        osc_at = o;
    endfunction

    function automatic int beats_of(input logic [1:0] md);
        beats_of = (md == 2'b01) ? NOTES : 2 * NOTES - 1;
    endfunction

    function automatic int seq_len(input logic [1:0] md);
        seq_len = beats_of(md) * BEAT + (beats_of(md) - 1) * GAP_T;
    endfunction

    function automatic logic in_gap(input int off);
        in_gap = (off % SLOT) >= BEAT;
    endfunction

    // Channel sequenced at a given offset; during a gap it already names the next step.
    function automatic int step_at(input logic [1:0] md, input int off);
        int j;
        j = off / SLOT;
        if (in_gap(off)) j++;
        case (md)
            2'b01:   step_at = j;
            2'b10:   step_at = (j < NOTES) ? j : 2 * NOTES - 2 - j;
            default: step_at = j % NOTES;
        endcase
    endfunction

    function automatic model_t model_next(input model_t c, input logic [7:0] sw,
                                          input logic [1:0] md, input logic st);
        model_t     n;
        logic [7:0] gate;
        n = c;
        n.k = c.k + 1;
        if (c.done)      gate = 8'h00;
        else if (c.busy) gate = in_gap(int'(c.offset)) ? 8'h00 : ((8'(1) << c.step) & sw);
        else             gate = (md == 2'b00) ? sw : 8'h00;
        n.tone = osc_at(int'(c.k)) & gate;
        if (c.done) begin
            n.done = 1'b0;
        end else if (c.busy) begin
            if (md != c.mode || (c.mode == 2'b11 && st)) begin
                n.busy = 1'b0;
                n.done = 1'b1;
            end else begin
                n.offset = c.offset + 1;
                if (c.mode != 2'b11 && int'(n.offset) == seq_len(c.mode)) begin
                    n.busy = 1'b0;
                    n.done = 1'b1;
                end else begin
                    n.step = 3'(step_at(c.mode, int'(n.offset)));
                end
            end
        end else if (st && md != 2'b00) begin
            n.busy   = 1'b1;
            n.offset = 0;
            n.mode   = md;
            n.step   = 3'd0;
        end
        model_next = n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_next(m, bus.sw, bus.mode, bus.start);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("tone",     32'(bus.tone),     32'(m.tone));
        check("busy",     32'(bus.busy),     32'(m.busy));
        check("step_idx", 32'(bus.step_idx), 32'(m.step));
    end

    // ------------------------------------------------------------------
    // Directed sequences
    // ------------------------------------------------------------------
    task automatic run_seq(input string name, input logic [1:0] md, input logic [7:0] sws,
                           input int exp_len, input int probe_off, input int probe_step,
                           input int poke_off, output int off_mask_hits, output int hi2);
        int n;
        n             = 0;
        off_mask_hits = 0;
        hi2           = 0;
        bus.mode  = md;
        bus.sw    = sws;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check({name, "_busy_start"}, 32'(bus.busy), 32'd1);
        while (bus.busy === 1'b1 && n < 2000) begin
            if (n == probe_off) check({name, "_probe_step"}, 32'(bus.step_idx), 32'(probe_step));
            if ((bus.tone & ~sws) != 8'h00) off_mask_hits++;
            if (bus.tone[2]) hi2++;
            bus.start = (n == poke_off);
            tick(1);
            n++;
        end
        bus.start = 1'b0;
        check({name, "_len"}, 32'(n), 32'(exp_len));
        tick(2);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int mask_hits;
        int hi2;

        bus.sw    = 8'h00;
        bus.mode  = 2'b00;
        bus.start = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_tone",  32'(bus.tone),     32'd0);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_step",  32'(bus.step_idx), 32'd0);
        tick(2);
        rst = 1'b0;

        // LIVE, sw=01: tone[0] high after clocks 11..20, low 21..30 (period 20).
        bus.sw = 8'h01;
        tick(10);
        check("live_t10", 32'(bus.tone), 32'h00);
        tick(1);
        check("live_t11", 32'(bus.tone), 32'h01);
        tick(9);
        check("live_t20", 32'(bus.tone), 32'h01);
        tick(1);
        check("live_t21", 32'(bus.tone), 32'h00);
        tick(10);
        check("live_t31", 32'(bus.tone), 32'h01);
        bus.sw = 8'h00;
        tick(1);
        check("live_off", 32'(bus.tone), 32'h00);
        bus.sw = 8'hFF;
        tick(30);
        bus.start = 1'b1;          // ignored in LIVE
        tick(1);
        bus.start = 1'b0;
        check("live_start_ignored", 32'(bus.busy), 32'd0);
        tick(5);

        // ASCEND across all channels.
        run_seq("asc", 2'b01, 8'hFF, ASC_LEN, 120, ASC_PROBE_STEP, -1, mask_hits, hi2);
        check("asc_last_step_held", 32'(bus.step_idx), 32'd7);

        // ASCEND with only channel 2 enabled: the other steps are rests.
        run_seq("rest", 2'b01, 8'h04, ASC_LEN, 90, 2, -1, mask_hits, hi2);
        check("rest_other_channels", 32'(mask_hits), 32'd0);
        check("rest_ch2_sounds", 32'(hi2 > 0), 32'd1);

        // PINGPONG with a second start mid-run that must be ignored.
        run_seq("pp", 2'b10, 8'hFF, PP_LEN, 320, PP_PROBE_STEP, 300, mask_hits, hi2);
        check("pp_end_step", 32'(bus.step_idx), 32'd0);

        // Mode change while busy aborts on the next clock.
        bus.mode  = 2'b01;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(50);
        bus.mode = 2'b10;
        tick(1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_step", 32'(bus.step_idx), 32'd1);
        tick(3);

        // LOOP wraps, then start stops it.
        bus.mode  = 2'b11;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("loop_busy", 32'(bus.busy), 32'd1);
        tick(330);
        check("loop_wrap_step", 32'(bus.step_idx), 32'(LOOP_PROBE_STEP));
        check("loop_still_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("loop_stop_busy", 32'(bus.busy), 32'd0);
        tick(3);

        // LOOP again, asynchronous reset at step 3 between clock edges.
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(130);
        check("loop_pre_rst_step", 32'(bus.step_idx), 32'd3);
        check("loop_pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tone", 32'(bus.tone),     32'd0);
        check("async_rst_busy", 32'(bus.busy),     32'd0);
        check("async_rst_step", 32'(bus.step_idx), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("post_rst_idle", 32'(bus.busy), 32'd0);

        // Oscillators restart from zero phase after reset.
        bus.mode = 2'b00;
        bus.sw   = 8'h01;
        tick(30);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 25000000, input clock frequency in Hz.
REQ-002 Parameter NOTES, default 8, number of note channels (1..8); channel i uses scale entry i of {262,294,330,349,392,440,494,523} Hz.
REQ-003 Parameter CW, default 20, width of each oscillator and beat counter.
REQ-004 Parameter BEAT_CYCLES, default 6250000, length of one sequenced step in clocks (>=1).
REQ-005 Parameter GAP_CYCLES, default 250000, silence inserted between steps when gap is compiled in (>=1).
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 sw  input  NOTES  per-channel enable; sw[i] gates channel i.
REQ-009 mode  input  2  00 LIVE, 01 ASCEND, 10 PINGPONG, 11 LOOP.
REQ-010 start  input  1  single-cycle request to begin a sequence.
REQ-011 tone  output  NOTES  registered square wave per channel.
REQ-012 busy  output  1  high while a sequence is running.
REQ-013 step_idx  output  3  index of the channel currently sequenced.

Function
REQ-014 Channel i shall have half-period HALF[i] = CLK_HZ/(2*freq[i]) (integer floor); its counter counts 0..HALF[i]-1, then wraps to 0 and toggles osc[i], giving a period of exactly 2*HALF[i] clocks.
REQ-015 Oscillators shall run continuously, independent of mode or gating (phase-continuous).
REQ-016 tone[i] shall equal osc[i] AND gate[i], registered, one clock after both inputs are valid.
REQ-017 FSM states: IDLE, PLAY, GAP, DONE; busy shall be high exactly in PLAY and GAP.
REQ-018 In IDLE with mode LIVE, gate = sw; start is ignored.
REQ-019 In IDLE with any other mode, gate = 0; start moves to PLAY with step_idx=0 and a cleared beat counter.
REQ-020 In PLAY, gate = one-hot(step_idx) AND sw; a disabled channel is a silent rest lasting a full beat.
REQ-021 PLAY shall last BEAT_CYCLES clocks, then advance (through GAP if compiled in).
REQ-022 ASCEND: steps 0..NOTES-1, then DONE; total NOTES beats.
REQ-023 PINGPONG: steps 0..NOTES-1 then NOTES-2..0, then DONE; total 2*NOTES-1 beats (1 beat if NOTES=1).
REQ-024 LOOP: steps 0..NOTES-1 repeating; wraps NOTES-1 -> 0 without DONE.
REQ-025 DONE shall last one clock, with gate = 0, then return to IDLE.
REQ-026 start while busy shall be ignored in ASCEND/PINGPONG; in LOOP it shall stop the sequence (next state DONE).
REQ-027 A change of mode while busy shall abort to DONE on the next clock.
REQ-028 step_idx shall hold its last value in IDLE and be cleared on start.

Reset
REQ-029 While rst is high: all oscillator counters and osc = 0, beat counter = 0, tone = 0, busy = 0, step_idx = 0, state = IDLE; the effect is immediate, without waiting for a clock edge.
REQ-030 After rst deasserts, oscillators restart from 0 and no sequence resumes until a new start.

Configuration
REQ-031 Macro TONE_SEQUENCER_GAP_EN defined: each PLAY->PLAY transition shall pass through GAP for GAP_CYCLES clocks with gate = 0; no GAP follows the final step.
REQ-032 Macro TONE_SEQUENCER_GAP_EN undefined: GAP state absent, steps are back-to-back, GAP_CYCLES ignored.

Verification (CLK_HZ=5240 -> HALF = 10,8,7,7,6,5,5,5; BEAT_CYCLES=40)
REQ-033 LIVE, sw=8'h01 -> tone[0] toggles every 10 clocks (period 20), tone[7:1]=0; sw=8'h00 -> all tone 0 within 1 clock.
REQ-034 ASCEND, sw=8'hFF, start pulse -> busy high next clock, step_idx 0..7 at 40 clocks each, busy low after 320 clocks, DONE then IDLE.
REQ-035 PINGPONG, sw=8'hFF -> step_idx 0,1..7,6..0 (15 steps, 600 clocks); second start during run is ignored.
REQ-036 ASCEND, sw=8'h04 -> tone[2] active only during step 2 (period 14); all tone 0 during other steps.
REQ-037 LOOP running, rst asserted at step 3 -> tone=0, busy=0, step_idx=0 without a clock edge; IDLE after release.
REQ-038 GAP_EN defined, GAP_CYCLES=4, ASCEND -> 4 silent clocks between steps with busy high; total 320+28 clocks.
